regfile_wb_arbiter: RTL

Write-back arbiter and sequencer for the dual-write-port register file. Each cycle it merges two requesters into the register file's single shared write enable: the pipeline write-back stage, which issues single writes and can never be held off, and the multiply/divide unit, which issues paired writes (two destinations, e.g. LO/HI) and can wait in a small buffer. It also guards register 0, prevents starvation of the mul/div unit, and drives the register file's write port from registers.

---
 rtl/regfile_wb_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges pipeline single writes and buffered mul/div pair writes
// onto the register file's shared write port, with register-0 guard and starvation stall.
module regfile_wb_arbiter #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pipe_we,
    input  logic [4:0]       pipe_wa,
    input  logic [WIDTH-1:0] pipe_wd,
    input  logic             md_valid,
    output logic             md_ready,
    input  logic [4:0]       md_wa1,
    input  logic [4:0]       md_wa2,
    input  logic [WIDTH-1:0] md_wd1,
    input  logic [WIDTH-1:0] md_wd2,
    output logic             rf_we,
    output logic [4:0]       rf_w1,
    output logic [4:0]       rf_w2,
    output logic [WIDTH-1:0] rf_din1,
    output logic [WIDTH-1:0] rf_din2,
    output logic             stall_req,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_PEND, S_STARVE} state_t;

    logic [4:0]       r_mem_wa1 [DEPTH];
    logic [4:0]       r_mem_wa2 [DEPTH];
    logic [WIDTH-1:0] r_mem_wd1 [DEPTH];
    logic [WIDTH-1:0] r_mem_wd2 [DEPTH];
    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [WW-1:0]    r_wait_cnt;
    state_t           r_state;

    logic             r_rf_we;
    logic [4:0]       r_rf_w1;
    logic [4:0]       r_rf_w2;
    logic [WIDTH-1:0] r_rf_din1;
    logic [WIDTH-1:0] r_rf_din2;

    logic             w_empty;
    logic             w_accept;
    logic             w_sel_head;
    logic             w_sel_bypass;
    logic             w_push;
    logic             w_pop;
    logic             w_blocked;
    logic [CW-1:0]    w_count_next;
    logic [4:0]       w_src_wa1;
    logic [4:0]       w_src_wa2;
    logic [WIDTH-1:0] w_src_wd1;
    logic [WIDTH-1:0] w_src_wd2;
    logic             w_issue_we;
    logic [4:0]       w_issue_w1;
    logic [4:0]       w_issue_w2;
    logic [WIDTH-1:0] w_issue_d1;
    logic [WIDTH-1:0] w_issue_d2;
    state_t           w_next_state;
    logic [WW-1:0]    w_next_wait;
    logic             w_stall;

    assign w_empty      = (r_count == '0);
    assign md_ready     = (r_count != FULL);
    assign busy         = !w_empty;
    assign w_accept     = md_valid && md_ready;
    assign w_sel_head   = !pipe_we && !w_empty;
    assign w_sel_bypass = !pipe_we && w_empty && md_valid;
    assign w_push       = w_accept && !w_sel_bypass;
    assign w_pop        = w_sel_head;
    assign w_blocked    = pipe_we && !w_empty;

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_comb begin
        if (w_sel_head) begin
            w_src_wa1 = r_mem_wa1[r_head];
            w_src_wa2 = r_mem_wa2[r_head];
            w_src_wd1 = r_mem_wd1[r_head];
            w_src_wd2 = r_mem_wd2[r_head];
        end else begin
            w_src_wa1 = md_wa1;
            w_src_wa2 = md_wa2;
            w_src_wd1 = md_wd1;
            w_src_wd2 = md_wd2;
        end
    end

    // A zero destination in a pair is folded onto its partner so register 0 is never written.
    always_comb begin
        w_issue_we = 1'b0;
        w_issue_w1 = '0;
        w_issue_w2 = '0;
        w_issue_d1 = '0;
        w_issue_d2 = '0;
        if (pipe_we) begin
            w_issue_we = (pipe_wa != 5'd0);
            w_issue_w1 = pipe_wa;
            w_issue_w2 = pipe_wa;
            w_issue_d1 = pipe_wd;
            w_issue_d2 = pipe_wd;
        end else if (w_sel_head || w_sel_bypass) begin
            w_issue_we = (w_src_wa1 != 5'd0) || (w_src_wa2 != 5'd0);
            w_issue_w1 = (w_src_wa1 == 5'd0) ? w_src_wa2 : w_src_wa1;
            w_issue_d1 = (w_src_wa1 == 5'd0) ? w_src_wd2 : w_src_wd1;
            w_issue_w2 = (w_src_wa2 == 5'd0) ? w_src_wa1 : w_src_wa2;
            w_issue_d2 = (w_src_wa2 == 5'd0) ? w_src_wd1 : w_src_wd2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_wa1[r_tail] <= md_wa1;
            r_mem_wa2[r_tail] <= md_wa2;
            r_mem_wd1[r_tail] <= md_wd1;
            r_mem_wd2[r_tail] <= md_wd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we   <= 1'b0;
            r_rf_w1   <= '0;
            r_rf_w2   <= '0;
            r_rf_din1 <= '0;
            r_rf_din2 <= '0;
        end else begin
            r_rf_we <= w_issue_we;
            if (w_issue_we) begin
                r_rf_w1   <= w_issue_w1;
                r_rf_w2   <= w_issue_w2;
                r_rf_din1 <= w_issue_d1;
                r_rf_din2 <= w_issue_d2;
            end
        end
    end

    assign rf_we   = r_rf_we;
    assign rf_w1   = r_rf_w1;
    assign rf_w2   = r_rf_w2;
    assign rf_din1 = r_rf_din1;
    assign rf_din2 = r_rf_din2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait;
        end
    end

    // wait_cnt only advances while the head is held off; it saturates once STARVE is entered.
    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_count_next != '0) begin
                    w_next_state = S_PEND;
                end
            end
            S_PEND: begin
                if (w_pop) begin
                    w_next_wait  = '0;
                    w_next_state = (w_count_next != '0) ? S_PEND : S_IDLE;
                end else if (w_blocked) begin
                    w_next_wait = r_wait_cnt + WW'(1);
                    if (r_wait_cnt + WW'(1) == LIMIT) begin
                        w_next_state = S_STARVE;
                    end
                end
            end
            S_STARVE: begin
                if (w_pop) begin
                    w_next_wait  = '0;
                    w_next_state = (w_count_next != '0) ? S_PEND : S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_wait  = '0;
            end
        endcase
    end

    always_comb begin
        w_stall = (r_state == S_STARVE);
    end

    assign stall_req = w_stall;

endmodule
